// File: rtl/gcd_lcm_unit.sv
// Iterative GCD (subtractive Euclid) / LCM (dual-accumulator) coprocessor with decoder stall.
// Optional LCM overflow detection is enabled by defining GCDLCM_OVF_EN.
module gcd_lcm_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             stall,
    output logic             ovf
);

    localparam int AW = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    x_q, x_d;
    logic [AW-1:0]    y_q, y_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             m_q, m_d;
    logic             done_q, done_d;

`ifdef GCDLCM_OVF_EN
    logic ovf_q, ovf_d;
    logic acc_big;

    // An accumulator above 2^WIDTH-1 means the true LCM cannot fit in the result.
    assign acc_big = (|x_q[AW-1:WIDTH]) | (|y_q[AW-1:WIDTH]);
`endif

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        result_d = result_q;
        m_d      = m_q;
        done_d   = 1'b0;
`ifdef GCDLCM_OVF_EN
        ovf_d    = ovf_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if ((a == '0) || (b == '0)) begin
                        // With one operand zero, a|b is the other operand (and 0 for gcd(0,0)).
                        result_d = op ? '0 : (a | b);
                        done_d   = 1'b1;
                        state_d  = S_DONE;
`ifdef GCDLCM_OVF_EN
                        ovf_d    = 1'b0;
`endif
                    end else begin
                        x_d     = {{WIDTH{1'b0}}, a};
                        y_d     = {{WIDTH{1'b0}}, b};
                        sa_d    = a;
                        sb_d    = b;
                        m_d     = op;
                        state_d = S_RUN;
                    end
                end
            end

            S_RUN: begin
                if (!start) begin
                    state_d = S_IDLE;
`ifdef GCDLCM_OVF_EN
                end else if (m_q && acc_big) begin
                    result_d = '1;
                    ovf_d    = 1'b1;
                    done_d   = 1'b1;
                    state_d  = S_DONE;
`endif
                end else if (x_q == y_q) begin
                    result_d = x_q[WIDTH-1:0];
                    done_d   = 1'b1;
                    state_d  = S_DONE;
`ifdef GCDLCM_OVF_EN
                    ovf_d    = 1'b0;
`endif
                end else if (!m_q) begin
                    if (x_q > y_q) begin
                        x_d = x_q - y_q;
                    end else begin
                        y_d = y_q - x_q;
                    end
                end else begin
                    // LCM: advance whichever multiple is behind.
                    if (x_q < y_q) begin
                        x_d = x_q + {{WIDTH{1'b0}}, sa_q};
                    end else begin
                        y_d = y_q + {{WIDTH{1'b0}}, sb_q};
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            x_q      <= '0;
            y_q      <= '0;
            sa_q     <= '0;
            sb_q     <= '0;
            result_q <= '0;
            m_q      <= 1'b0;
            done_q   <= 1'b0;
`ifdef GCDLCM_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            result_q <= result_d;
            m_q      <= m_d;
            done_q   <= done_d;
`ifdef GCDLCM_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign result = result_q;
    assign done   = done_q;
    assign stall  = start & (state_q != S_DONE);

`ifdef GCDLCM_OVF_EN
    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_gcd_lcm_unit.sv
// Self-checking bench for gcd_lcm_unit: directed vector table, hand sequences, and random ops vs. a math model.
module tb_gcd_lcm_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
    logic        done;
    logic        stall;
    logic        ovf;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef GCDLCM_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    gcd_lcm_unit #(.WIDTH(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .result (result),
        .done   (done),
        .stall  (stall),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        logic        exp_ovf;
        int          exp_stalls;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: Euclid by modulo, LCM via 64-bit product; no cycle-level modelling.
    function automatic logic [32:0] ref_op(input logic o, input logic [31:0] x, input logic [31:0] y);
        longint unsigned p, q, t, l;
        p = x;
        q = y;
        while (q != 0) begin
            t = p % q;
            p = q;
            q = t;
        end
        if (!o) return {1'b0, p[31:0]};
        if (x == 0 || y == 0) return 33'd0;
        l = (longint'(x) / p) * longint'(y);
        if (OVF_EN && l > 64'h0000_0000_FFFF_FFFF) return {1'b1, 32'hFFFF_FFFF};
        return {1'b0, l[31:0]};
    endfunction

    // Entered and left at posedge+1 with the unit idle; start is dropped during the done cycle.
    task automatic do_op(input logic top, input logic [31:0] ta, input logic [31:0] tb,
                         output int stalls, output logic got_done, output logic [31:0] res,
                         output logic res_ovf, output logic stall_at_done);
        start = 1'b1;
        op = top;
        a = ta;
        b = tb;
        stalls = 0;
        got_done = 1'b0;
        res = '0;
        res_ovf = 1'b0;
        stall_at_done = 1'b0;
        for (int i = 0; i < 2000 && !got_done; i++) begin
            #1;
            if (done) begin
                got_done = 1'b1;
                res = result;
                res_ovf = ovf;
                stall_at_done = stall;
                start = 1'b0;
            end else if (stall) begin
                stalls++;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
    endtask

    initial begin
        int          stalls;
        logic        got_done;
        logic [31:0] res;
        logic        res_ovf;
        logic        sad;
        logic [32:0] exp;

        reset = 1'b0;
        start = 1'b0;
        op = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_result", result, 0);
        check("reset_done", done, 0);
        check("reset_ovf", ovf, 0);
        check("reset_stall_lo", stall, 0);
        start = 1'b1;
        #1;
        check("reset_stall_follows_start", stall, 1);
        start = 1'b0;
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;

        vecs.push_back('{1'b0, 32'd12, 32'd18, 32'd6, 1'b0, 4});
        vecs.push_back('{1'b1, 32'd4, 32'd6, 32'd12, 1'b0, 5});
        vecs.push_back('{1'b0, 32'd0, 32'd7, 32'd7, 1'b0, 1});
        vecs.push_back('{1'b1, 32'd0, 32'd7, 32'd0, 1'b0, 1});
        vecs.push_back('{1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1});
        vecs.push_back('{1'b0, 32'd5, 32'd0, 32'd5, 1'b0, 1});
        vecs.push_back('{1'b1, 32'd7, 32'd0, 32'd0, 1'b0, 1});
        vecs.push_back('{1'b0, 32'd7, 32'd7, 32'd7, 1'b0, 2});
        vecs.push_back('{1'b1, 32'd5, 32'd5, 32'd5, 1'b0, 2});
        vecs.push_back('{1'b0, 32'd9, 32'd6, 32'd3, 1'b0, 4});
        vecs.push_back('{1'b1, 32'd3, 32'd5, 32'd15, 1'b0, 8});
`ifdef GCDLCM_OVF_EN
        vecs.push_back('{1'b1, 32'h8000_0000, 32'hC000_0000, 32'hFFFF_FFFF, 1'b1, 3});
        vecs.push_back('{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b1, 3});
        vecs.push_back('{1'b0, 32'd12, 32'd18, 32'd6, 1'b0, 4});
`else
        vecs.push_back('{1'b1, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000, 1'b0, 5});
`endif

        foreach (vecs[i]) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, stalls, got_done, res, res_ovf, sad);
            $display("vec %0d op=%0d a=%0h b=%0h -> result=%0h ovf=%0d stalls=%0d",
                     i, vecs[i].op, vecs[i].a, vecs[i].b, res, res_ovf, stalls);
            check($sformatf("vec%0d_done", i), got_done, 1);
            check($sformatf("vec%0d_result", i), res, vecs[i].exp_res);
            check($sformatf("vec%0d_ovf", i), res_ovf, vecs[i].exp_ovf);
            check($sformatf("vec%0d_stalls", i), stalls, vecs[i].exp_stalls);
            check($sformatf("vec%0d_stall_at_done", i), sad, 0);
            check($sformatf("vec%0d_done_single", i), done, 0);
        end

        // Back-to-back: start stays high across both instructions.
        begin
            int          dcount;
            int          first_c;
            int          second_c;
            int          gap_bad;
            logic [31:0] r1;
            logic [31:0] r2;
            dcount = 0;
            first_c = -1;
            second_c = -1;
            gap_bad = 0;
            r1 = '0;
            r2 = '0;
            start = 1'b1;
            op = 1'b0;
            a = 32'd9;
            b = 32'd6;
            for (int c = 0; c < 200 && dcount < 2; c++) begin
                #1;
                if (done) begin
                    if (dcount == 0) begin
                        r1 = result;
                        first_c = c;
                        op = 1'b1;
                        a = 32'd3;
                        b = 32'd5;
                    end else begin
                        r2 = result;
                        second_c = c;
                        start = 1'b0;
                    end
                    dcount++;
                end else if (!stall) begin
                    gap_bad++;
                end
                @(posedge clk);
                #1;
            end
            start = 1'b0;
            $display("b2b gcd(9,6)=%0d lcm(3,5)=%0d done_cycles=%0d,%0d", r1, r2, first_c, second_c);
            check("b2b_done_count", dcount, 2);
            check("b2b_first_result", r1, 3);
            check("b2b_second_result", r2, 15);
            check("b2b_done_spacing", second_c - first_c, 9);
            check("b2b_no_idle_gap", gap_bad, 0);
        end

        // Flush: drop start mid-RUN; previous result survives, no done.
        begin
            int dseen;
            do_op(1'b0, 32'd12, 32'd18, stalls, got_done, res, res_ovf, sad);
            check("flush_pre_result", res, 6);
            start = 1'b1;
            op = 1'b0;
            a = 32'd1000;
            b = 32'd3;
            repeat (3) @(posedge clk);
            #1;
            check("flush_stall_in_run", stall, 1);
            start = 1'b0;
            #1;
            check("flush_stall_drop", stall, 0);
            dseen = 0;
            repeat (6) begin
                @(posedge clk);
                #1;
                if (done) dseen++;
            end
            $display("flush gcd(1000,3) aborted: result=%0d done_seen=%0d", result, dseen);
            check("flush_no_done", dseen, 0);
            check("flush_result_kept", result, 6);
            check("flush_ovf_kept", ovf, 0);
            do_op(1'b0, 32'd9, 32'd6, stalls, got_done, res, res_ovf, sad);
            check("flush_after_result", res, 3);
            check("flush_after_stalls", stalls, 4);
        end

        // Asynchronous reset mid-RUN of gcd(1000,3).
        start = 1'b1;
        op = 1'b0;
        a = 32'd1000;
        b = 32'd3;
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        $display("reset mid-run: result=%0h done=%0d stall=%0d", result, done, stall);
        check("midrst_result", result, 0);
        check("midrst_done", done, 0);
        check("midrst_ovf", ovf, 0);
        check("midrst_stall_eq_start", stall, 1);
        start = 1'b0;
        #1;
        check("midrst_stall_low", stall, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_done_after", done, 0);
        do_op(1'b0, 32'd12, 32'd18, stalls, got_done, res, res_ovf, sad);
        check("midrst_after_result", res, 6);
        check("midrst_after_stalls", stalls, 4);

        // Random operations against the arithmetic model.
        for (int i = 0; i < 60; i++) begin
            logic        rop;
            logic [31:0] ra;
            logic [31:0] rb;
            int          mode;
            longint unsigned m;
            rop = 1'($urandom_range(0, 1));
            mode = $urandom_range(0, 3);
            if (mode == 0) begin
                ra = 32'($urandom_range(0, 300));
                rb = 32'($urandom_range(0, 300));
            end else if (mode == 3) begin
                ra = ($urandom_range(0, 1) == 1) ? 32'd0 : $urandom;
                rb = (ra != 0) ? 32'd0 : $urandom;
            end else begin
                m = longint'($urandom_range(1, 32'h00FF_FFFF));
                ra = 32'(m * longint'($urandom_range(1, 255)));
                rb = 32'(m * longint'($urandom_range(1, 255)));
            end
            exp = ref_op(rop, ra, rb);
            do_op(rop, ra, rb, stalls, got_done, res, res_ovf, sad);
            $display("rand %0d op=%0d a=%0h b=%0h -> result=%0h ovf=%0d (model %0h/%0d)",
                     i, rop, ra, rb, res, res_ovf, exp[31:0], exp[32]);
            check($sformatf("rand%0d_done", i), got_done, 1);
            check($sformatf("rand%0d_result", i), res, exp[31:0]);
            check($sformatf("rand%0d_ovf", i), res_ovf, exp[32]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
